// File: rtl/spi_byte_master_if.sv
// Byte-request and SPI pin bundle for spi_byte_master.
// Handshake: a byte is accepted in a cycle where tx_valid and tx_ready are both 1; rx_valid is a one-cycle strobe with no ready.
interface spi_byte_master_if #(
  parameter int DIV_W = 8
);
  logic [DIV_W-1:0] div;
  logic             cs_en;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             busy;
  logic             sck;
  logic             mosi;
  logic             miso;
  logic             ss;

  // slave: the byte engine; master: its user plus the card on miso
  modport slave (
    input  div, cs_en, tx_valid, tx_data, miso,
    output tx_ready, rx_valid, rx_data, busy, sck, mosi, ss
  );

  modport master (
    output div, cs_en, tx_valid, tx_data, miso,
    input  tx_ready, rx_valid, rx_data, busy, sck, mosi, ss
  );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte initiator: shifts one byte out on mosi MSB first while capturing miso.
// SCK high and low phases each last div+1 clk_sys cycles; div is captured with the byte.
module spi_byte_master #(
  parameter int DIV_W = 8
) (
  input  logic             clk_sys,
  input  logic             hard_reset_n,
  spi_byte_master_if.slave bus,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] half_cnt;
  logic [7:0]       shift;
  logic [2:0]       bit_cnt;
  logic             sck_r;
  logic             mosi_r;
  logic             ss_r;
  logic             rx_valid_r;
  logic [7:0]       rx_data_r;

  always_ff @(posedge clk_sys or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state      <= ST_IDLE;
      div_r      <= '0;
      half_cnt   <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b1;
      ss_r       <= 1'b1;
      rx_valid_r <= 1'b0;
      rx_data_r  <= '0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          // card select follows cs_en only between bytes
          ss_r <= ~bus.cs_en;
          if (bus.tx_valid) begin
            shift    <= bus.tx_data;
            mosi_r   <= bus.tx_data[7];
            div_r    <= bus.div;
            half_cnt <= bus.div;
            bit_cnt  <= 3'd7;
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (half_cnt == '0) begin
            // miso is captured on the same clk_sys edge that raises sck
            sck_r    <= 1'b1;
            shift    <= {shift[6:0], bus.miso};
            half_cnt <= div_r;
            state    <= ST_HIGH;
          end else begin
            half_cnt <= half_cnt - DIV_W'(1);
          end
        end
        ST_HIGH: begin
          if (half_cnt == '0) begin
            sck_r    <= 1'b0;
            half_cnt <= div_r;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
              mosi_r  <= shift[7];
              state   <= ST_LOW;
            end else begin
              rx_data_r  <= shift;
              rx_valid_r <= 1'b1;
              mosi_r     <= 1'b1;
              state      <= ST_DONE;
            end
          end else begin
            half_cnt <= half_cnt - DIV_W'(1);
          end
        end
        default: begin
          mosi_r <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready = (state == ST_IDLE);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.sck      = sck_r;
  assign bus.mosi     = mosi_r;
  assign bus.ss       = ss_r;
  assign fsm_state    = state;

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master: loopback, byte responder and a tiny SD-card reply model.
`timescale 1ns/1ps
module tb_spi_byte_master;

  logic       clk_sys = 1'b0;
  logic       hard_reset_n = 1'b0;
  logic [1:0] fsm_state;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  spi_byte_master_if #(.DIV_W(8)) bus ();

  spi_byte_master #(.DIV_W(8)) dut (
    .clk_sys      (clk_sys),
    .hard_reset_n (hard_reset_n),
    .bus          (bus),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // card side: loopback or a responder shifting resp_byte out on falling sck
  logic       loopback = 1'b1;
  logic [7:0] resp_byte = 8'hFF;
  int         resp_idx = 0;
  always @(negedge bus.sck) if (resp_idx < 7) resp_idx = resp_idx + 1;
  assign bus.miso = loopback ? bus.mosi : resp_byte[7 - resp_idx];

  // tiny SD model: expected reply bytes queued after a CMD0 frame
  logic [7:0] card_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];

  int t_hs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sends one byte; the expected rx byte is pushed by the caller onto exp_q.
  task automatic do_byte(input logic [7:0] tx, input logic [7:0] d, input bit hold,
                         input int cs_drop, output logic [7:0] rx);
    int n, budget, run, rises, bad, ss_bad;
    logic prev;
    logic [7:0] bits, exp_rx;
    budget = 16 * (int'(d) + 1) + 50;
    bus.tx_data = tx;
    bus.div = d;
    bus.tx_valid = 1'b1;
    n = 0;
    while (!bus.tx_ready && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("hs_wait", n < 50, 1);
    check("mosi_idle", bus.mosi, 1);
    resp_idx = 0;
    t_hs = cyc;
    @(negedge clk_sys);
    if (!hold) bus.tx_valid = 1'b0;
    bus.tx_data = ~tx;
    bus.div = 8'($urandom_range(0, 255));
    prev = 1'b0; run = 0; rises = 0; bad = 0; ss_bad = 0; bits = '0; n = 0;
    while (!bus.rx_valid && n < budget) begin
      if (cs_drop >= 0 && cyc == t_hs + cs_drop) bus.cs_en = 1'b0;
      if (bus.busy !== 1'b1 || bus.tx_ready !== 1'b0) bad++;
      if (bus.sck !== prev) begin
        if (run != int'(d) + 1) bad++;
        run = 0;
        if (bus.sck) begin
          rises++;
          bits = {bits[6:0], bus.mosi};
        end
      end
      run++;
      prev = bus.sck;
      if (cs_drop >= 0 && bus.ss !== 1'b0) ss_bad++;
      @(negedge clk_sys);
      n++;
    end
    check("rx_timeout", n < budget, 1);
    check("phases", bad + ((run != int'(d) + 1) ? 1 : 0) + ((bus.sck !== 1'b0) ? 1 : 0), 0);
    check("sck_rises", rises, 8);
    check("mosi_bits", bits, tx);
    check("rx_latency", cyc - t_hs, 16 * (int'(d) + 1) + 1);
    check("mosi_done", bus.mosi, 1);
    check("no_hs_on_rx", bus.tx_ready, 0);
    if (cs_drop >= 0) check("ss_held", ss_bad, 0);
    exp_rx = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    rx = bus.rx_data;
    check("rx_data", rx, exp_rx);
  endtask

  // Card-model byte: choose what the card answers, send, and track CMD frames.
  task automatic card_byte(input logic [7:0] tx, output logic [7:0] rx);
    loopback = 1'b0;
    resp_byte = (card_q.size() > 0) ? card_q.pop_front() : 8'hFF;
    exp_q.push_back(resp_byte);
    do_byte(tx, 8'd0, 1'b0, -1, rx);
    if (bus.cs_en) begin
      frame_q.push_back(tx);
      if (frame_q.size() == 6) begin
        if (frame_q[0] == 8'h40 && frame_q[5] == 8'h95) begin
          card_q.push_back(8'hFF);
          card_q.push_back(8'h01);
        end
        frame_q.delete();
      end
    end
  endtask

  initial begin
    logic [7:0] rx, tx, d;
    logic [7:0] cmd0[6];
    int t1, k, found;
    bus.div = '0; bus.cs_en = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_sck", bus.sck, 0);
    check("rst_mosi", bus.mosi, 1);
    check("rst_ss", bus.ss, 1);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rx", {bus.rx_valid, bus.rx_data}, 0);
    hard_reset_n = 1'b1;
    @(negedge clk_sys);

    // 1: loopback at full speed
    loopback = 1'b1;
    exp_q.push_back(8'hA5);
    do_byte(8'hA5, 8'd0, 1'b0, -1, rx);
    @(negedge clk_sys);
    check("rx_pulse", bus.rx_valid, 0);

    // 2: responder, div=3
    loopback = 1'b0; resp_byte = 8'h3C;
    exp_q.push_back(8'h3C);
    do_byte(8'h96, 8'd3, 1'b0, -1, rx);
    @(negedge clk_sys);

    // 3: back-to-back with tx_valid held
    loopback = 1'b1;
    exp_q.push_back(8'h40);
    do_byte(8'h40, 8'd0, 1'b1, -1, rx);
    t1 = t_hs;
    exp_q.push_back(8'h00);
    do_byte(8'h00, 8'd0, 1'b0, -1, rx);
    check("b2b_gap", t_hs - t1, 18);
    @(negedge clk_sys);

    // 4: cs_en dropped mid-byte
    bus.cs_en = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("ss_assert", bus.ss, 0);
    exp_q.push_back(8'h81);
    do_byte(8'h81, 8'd1, 1'b0, 5, rx);
    @(negedge clk_sys);
    check("ss_first_idle", bus.ss, 0);
    @(negedge clk_sys);
    check("ss_release", bus.ss, 1);

    // randomized bytes against the reference rule rx = loopback ? tx : resp_byte
    for (int i = 0; i < 12; i++) begin
      tx = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 3));
      loopback = 1'($urandom_range(0, 1));
      resp_byte = 8'($urandom_range(0, 255));
      exp_q.push_back(loopback ? tx : resp_byte);
      do_byte(tx, d, 1'b0, -1, rx);
      @(negedge clk_sys);
      check("idle_after", {bus.rx_valid, bus.tx_ready, bus.mosi}, 3'b011);
    end

    // maximum divider: 256-cycle half-period
    loopback = 1'b0; resp_byte = 8'hE7;
    exp_q.push_back(8'hE7);
    do_byte(8'h18, 8'hFF, 1'b0, -1, rx);
    @(negedge clk_sys);

    // 5: async reset mid-byte, then a clean transfer
    loopback = 1'b1;
    bus.cs_en = 1'b1;
    bus.tx_data = 8'hC3; bus.div = 8'd2; bus.tx_valid = 1'b1;
    k = 0;
    while (!bus.tx_ready && k < 50) begin @(negedge clk_sys); k++; end
    t1 = cyc;
    @(negedge clk_sys);
    bus.tx_valid = 1'b0;
    while (cyc < t1 + 7) @(negedge clk_sys);
    check("busy_before_rst", bus.busy, 1);
    hard_reset_n = 1'b0;
    #1;
    check("arst_outs", {bus.sck, bus.mosi, bus.ss, bus.tx_ready, bus.busy, bus.rx_valid}, 6'b011100);
    check("arst_rx_data", bus.rx_data, 0);
    @(negedge clk_sys);
    hard_reset_n = 1'b1;
    bus.cs_en = 1'b0;
    @(negedge clk_sys);
    exp_q.push_back(8'h5A);
    do_byte(8'h5A, 8'd1, 1'b0, -1, rx);
    @(negedge clk_sys);

    // 6: SD init clocking, CMD0, poll for R1
    bus.cs_en = 1'b0;
    @(negedge clk_sys);
    for (int i = 0; i < 10; i++) card_byte(8'hFF, rx);
    bus.cs_en = 1'b1;
    repeat (2) @(negedge clk_sys);
    cmd0[0] = 8'h40; cmd0[1] = 8'h00; cmd0[2] = 8'h00;
    cmd0[3] = 8'h00; cmd0[4] = 8'h00; cmd0[5] = 8'h95;
    for (int i = 0; i < 6; i++) card_byte(cmd0[i], rx);
    found = 8;
    for (int i = 0; i < 8; i++) begin
      card_byte(8'hFF, rx);
      if (rx == 8'h01 && found == 8) found = i;
      if (found != 8) break;
    end
    check("r1_within_8", found < 8, 1);
    check("r1_value", rx, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
